// File: rtl/trace_port_tx_pkg.sv
// Shared definitions for the trace port transmitter: sync patterns, FSM states, width helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package trace_port_tx_pkg;

    // TPIU synchronisation patterns, sent LSB first
    localparam logic [31:0] FULLSYNC = 32'h7FFF_FFFF;
    localparam logic [15:0] HALFSYNC = 16'h7FFF;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Requested bus width: 1, 2 or 4; anything else falls back to 4
    function automatic logic [2:0] width_decode(input logic [2:0] w);
        case (w)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Bits driven on the pins for one slot; unused lanes are zero
    function automatic logic [3:0] slot_bits(input logic [31:0] data, input logic [2:0] w);
        case (w)
            3'd1:    return {3'b000, data[0]};
            3'd2:    return {2'b00, data[1:0]};
            default: return data[3:0];
        endcase
    endfunction

    // Remaining payload after one slot has been taken
    function automatic logic [31:0] shift_slot(input logic [31:0] data, input logic [2:0] w);
        case (w)
            3'd1:    return data >> 1;
            3'd2:    return data >> 2;
            default: return data >> 4;
        endcase
    endfunction

    // Index of the final slot of a word: (bits / w) - 1
    function automatic logic [4:0] last_slot_index(input logic [2:0] w, input logic is_sync);
        case (w)
            3'd1:    return is_sync ? 5'd31 : 5'd15;
            3'd2:    return is_sync ? 5'd15 : 5'd7;
            default: return is_sync ? 5'd7  : 5'd3;
        endcase
    endfunction

endpackage

// File: rtl/trace_port_tx_serialiser.sv
// Shifts 16/32-bit words onto the trace pins w bits per cycle and generates the DDR trace clock.
// Latency: a word loaded at lastSlot appears on the pins the next cycle; back-to-back with no gap.
// Backpressure: none; the next word must be presented whenever last_slot is high.
module trace_port_tx_serialiser
    import trace_port_tx_pkg::*;
(
    input  logic        clkOut,
    input  logic        rst,
    input  logic [31:0] nxt_dat,
    input  logic        nxt_is_sync,
    input  logic [2:0]  nxt_w,
    output logic [3:0]  dout,
    output logic        trace_clk,
    output logic        last_slot
);

    logic [31:0] sreg_q, sreg_d;
    logic [4:0]  slot_q, slot_d;
    logic [2:0]  cur_w_q, cur_w_d;
    logic [3:0]  dout_q, dout_d;
    logic        tclk_q, tclk_d;

    // slot_q counts slots left after the one on the pins; zero marks the final slot
    assign last_slot = (slot_q == 5'd0);
    assign dout      = dout_q;
    assign trace_clk = tclk_q;

    // Load the next word on the final slot, otherwise keep shifting the current one
    always_comb begin
        sreg_d  = sreg_q;
        slot_d  = slot_q;
        cur_w_d = cur_w_q;
        dout_d  = dout_q;
        tclk_d  = ~tclk_q;
        if (last_slot) begin
            dout_d  = slot_bits(nxt_dat, nxt_w);
            sreg_d  = shift_slot(nxt_dat, nxt_w);
            slot_d  = last_slot_index(nxt_w, nxt_is_sync);
            cur_w_d = nxt_w;
        end else begin
            dout_d  = slot_bits(sreg_q, cur_w_q);
            sreg_d  = shift_slot(sreg_q, cur_w_q);
            slot_d  = slot_q - 5'd1;
        end
    end

    // Reset leaves slot_q at zero so the first edge afterwards loads a word on a rising trace edge
    always_ff @(posedge clkOut) begin
        if (rst) begin
            sreg_q  <= '0;
            slot_q  <= '0;
            cur_w_q <= 3'd4;
            dout_q  <= '0;
            tclk_q  <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            slot_q  <= slot_d;
            cur_w_q <= cur_w_d;
            dout_q  <= dout_d;
            tclk_q  <= tclk_d;
        end
    end

endmodule

// File: rtl/trace_port_tx.sv
// Parallel trace port transmitter: halfwords in, 1/2/4-bit DDR trace bus out, with full/half sync insertion.
// Latency: an accepted halfword reaches the pins on the cycle after the handshake.
// Backpressure: txReady only in the final slot of the current word while no resync is pending.
module trace_port_tx
    import trace_port_tx_pkg::*;
#(
    parameter int MAX_BUS_WIDTH = 4,
    parameter int SYNC_WORDS    = 2,
    parameter int SYNC_PERIOD   = 0
) (
    input  logic                     clkOut,
    input  logic                     rst,
    input  logic [2:0]               width,
    input  logic [15:0]              txWd,
    input  logic                     txValid,
    output logic                     txReady,
    output logic [MAX_BUS_WIDTH-1:0] traceDout,
    output logic                     traceClkOut,
    output logic                     inSync,
    output logic                     idle
);

    state_t      state_q, state_d;
    logic [7:0]  sync_left_q, sync_left_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [2:0]  w_q, w_d;
    logic        in_sync_q, in_sync_d;
    logic        idle_q, idle_d;

    logic [2:0]  req_w;
    logic        sync_due;
    logic        last_slot;
    logic [31:0] nxt_dat;
    logic        nxt_is_sync;
    logic [2:0]  nxt_w;
    logic [3:0]  ser_dout;

    // Requested width, limited to what the pins can carry
    always_comb begin
        req_w = width_decode(width);
        if (req_w > 3'(MAX_BUS_WIDTH)) begin
            req_w = 3'(MAX_BUS_WIDTH);
        end
    end

    // A resync is owed after SYNC_PERIOD data words or whenever the requested width moves
    assign sync_due = ((SYNC_PERIOD != 0) && (word_cnt_q == 16'(SYNC_PERIOD))) || (req_w != w_q);

    assign txReady     = !rst && (state_q == RUN) && last_slot && !sync_due;
    assign traceDout   = ser_dout[MAX_BUS_WIDTH-1:0];
    assign inSync      = in_sync_q;
    assign idle        = idle_q;

    // Choose the next word for the serialiser at each final slot and advance the FSM
    always_comb begin
        state_d     = state_q;
        sync_left_d = sync_left_q;
        word_cnt_d  = word_cnt_q;
        w_d         = w_q;
        in_sync_d   = in_sync_q;
        idle_d      = idle_q;
        nxt_dat     = {16'h0000, HALFSYNC};
        nxt_is_sync = 1'b0;
        nxt_w       = w_q;
        if (last_slot) begin
            if (state_q == SYNC) begin
                if (sync_left_q != 8'd0) begin
                    nxt_dat     = FULLSYNC;
                    nxt_is_sync = 1'b1;
                    sync_left_d = sync_left_q - 8'd1;
                    idle_d      = 1'b0;
                end else begin
                    // Sync done; producer was not offered a slot, so fill with a half-sync
                    state_d   = RUN;
                    in_sync_d = 1'b1;
                    idle_d    = 1'b1;
                end
            end else if (sync_due) begin
                // First sync word goes out immediately at the newly latched width
                state_d     = SYNC;
                sync_left_d = 8'(SYNC_WORDS) - 8'd1;
                word_cnt_d  = '0;
                w_d         = req_w;
                nxt_w       = req_w;
                nxt_dat     = FULLSYNC;
                nxt_is_sync = 1'b1;
                idle_d      = 1'b0;
            end else if (txValid) begin
                nxt_dat    = {16'h0000, txWd};
                idle_d     = 1'b0;
                word_cnt_d = word_cnt_q + 16'd1;
            end else begin
                idle_d = 1'b1;
            end
        end
    end

    // FSM and sync scheduling state; width tracks the input throughout reset
    always_ff @(posedge clkOut) begin
        if (rst) begin
            state_q     <= SYNC;
            sync_left_q <= 8'(SYNC_WORDS);
            word_cnt_q  <= '0;
            w_q         <= req_w;
            in_sync_q   <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_left_q <= sync_left_d;
            word_cnt_q  <= word_cnt_d;
            w_q         <= w_d;
            in_sync_q   <= in_sync_d;
            idle_q      <= idle_d;
        end
    end

    trace_port_tx_serialiser u_ser (
        .clkOut      (clkOut),
        .rst         (rst),
        .nxt_dat     (nxt_dat),
        .nxt_is_sync (nxt_is_sync),
        .nxt_w       (nxt_w),
        .dout        (ser_dout),
        .trace_clk   (traceClkOut),
        .last_slot   (last_slot)
    );

endmodule
